// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the execute stage.
//
// Computes the 2*DATA_W-bit HI/LO result of MULT, MULTU, DIV and DIVU with one
// radix-2 step per clock. Signed operations run on operand magnitudes and the
// sign is applied in a final FIX cycle. While an operation is in flight the
// unit requests a pipeline stall; the result is then presented for one cycle
// on the HI/LO write port.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_i      launch request, sampled only while idle
//   op_i         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa_i        rs operand (multiplicand / dividend)
//   opb_i        rt operand (multiplier / divisor)
//   cancel_i     flush; aborts any operation, wins over start_i
//   stall_o      pipeline stall request (combinational)
//   res_valid_o  one-cycle pulse: hi_o/lo_o carry a new result
//   hi_o         product high half / remainder
//   lo_o         product low half / quotient
//   dbz_o        qualifies res_valid_o: divide with a zero divisor

module ex_muldiv #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              cancel_i,
    output logic              stall_o,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              dbz_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Counter value seen on the edge that performs the final iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Multiply: running partial product. Divide: {remainder, quotient}.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    // Multiply: multiplier, shifted right. Divide: dividend, shifted left.
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   a_q, a_d;        // multiplicand magnitude
    logic [DATA_W-1:0]   b_q, b_d;        // divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;  // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                dbz_q, dbz_d;
    logic                res_valid_q, res_valid_d;

    // ------------------------------------------------------------------
    // Launch-side decode
    // ------------------------------------------------------------------
    logic              op_signed;
    logic              op_div;
    logic              opa_neg;
    logic              opb_neg;
    logic [DATA_W-1:0] opa_mag;
    logic [DATA_W-1:0] opb_mag;
    logic              div_by_zero;

    always_comb begin
        op_signed   = ~op_i[0];
        op_div      = op_i[1];
        opa_neg     = op_signed & opa_i[DATA_W-1];
        opb_neg     = op_signed & opb_i[DATA_W-1];
        // The most-negative value maps onto itself, which is the correct
        // unsigned magnitude 2^(DATA_W-1).
        opa_mag     = opa_neg ? -opa_i : opa_i;
        opb_mag     = opb_neg ? -opb_i : opb_i;
        div_by_zero = op_div & (opb_i == '0);
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier bit is set, then shift the whole product right
        // one place. The carry out of the add becomes the new top bit.
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (sh_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        // Restoring division: bring the next dividend bit into the partial
        // remainder and subtract the divisor. The partial remainder is always
        // below the divisor, so DATA_W+1 bits hold the shifted value and the
        // top bit of the difference is a clean borrow flag.
        rem_sh   = {acc_q[2*DATA_W-1:DATA_W], sh_q[DATA_W-1]};
        div_diff = rem_sh - {1'b0, b_q};
        div_ge   = ~div_diff[DATA_W];
        div_next = {div_ge ? div_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0],
                    acc_q[DATA_W-2:0], div_ge};
    end

    // ------------------------------------------------------------------
    // Sign correction
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_raw;
    logic [DATA_W-1:0]   rem_raw;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        quo_raw  = acc_q[DATA_W-1:0];
        rem_raw  = acc_q[2*DATA_W-1:DATA_W];
        prod_fix = neg_res_q ? -acc_q : acc_q;
        // most-negative / -1 yields magnitude 2^(DATA_W-1) with no negation,
        // which is already the wrapped result.
        quo_fix  = neg_res_q ? -quo_raw : quo_raw;
        rem_fix  = neg_rem_q ? -rem_raw : rem_raw;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sh_d        = sh_q;
        a_d         = a_q;
        b_d         = b_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;
        res_valid_d = 1'b0;

        if (cancel_i) begin
            // Flush: drop the operation, keep the last presented result.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (div_by_zero) begin
                            // Answered immediately without iterating.
                            hi_d        = opa_i;
                            lo_d        = '1;
                            dbz_d       = 1'b1;
                            res_valid_d = 1'b1;
                        end else begin
                            state_d   = ST_RUN;
                            a_d       = opa_mag;
                            b_d       = opb_mag;
                            sh_d      = op_div ? opa_mag : opb_mag;
                            is_div_d  = op_div;
                            neg_res_d = opa_neg ^ opb_neg;
                            neg_rem_d = op_div & opa_neg;
                            cnt_d     = '0;
                            acc_d     = '0;
                        end
                    end
                end

                ST_RUN: begin
                    if (is_div_q) begin
                        acc_d = div_next;
                        sh_d  = sh_q << 1;
                    end else begin
                        acc_d = mul_next;
                        sh_d  = sh_q >> 1;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end

                ST_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d = prod_fix[DATA_W-1:0];
                    end
                    dbz_d       = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sh_q        <= sh_d;
            a_q         <= a_d;
            b_q         <= b_d;
            is_div_q    <= is_div_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dbz_q       <= dbz_d;
            res_valid_q <= res_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The stall is raised in the request cycle itself so the stage holds
    // while the operation is accepted, and drops while the result is shown.
    always_comb begin
        stall_o = ((state_q == ST_IDLE) & start_i & ~cancel_i)
                | (state_q == ST_RUN)
                | (state_q == ST_FIX);
    end

    assign res_valid_o = res_valid_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv.
// Directed table of known results, hand-written cancel/reset/back-to-back
// sequences, randomized operations against an arithmetic reference model,
// and a DATA_W=16 instance for latency scaling.

module tb_ex_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  opa, opb;
    logic          cancel;
    logic          stall, res_valid, dbz;
    logic [W-1:0]  hi, lo;

    logic          start16;
    logic [1:0]    op16;
    logic [15:0]   opa16, opb16;
    logic          cancel16;
    logic          stall16, rv16, dbz16;
    logic [15:0]   hi16, lo16;

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(W)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
        .cancel_i(cancel), .stall_o(stall), .res_valid_o(res_valid), .hi_o(hi),
        .lo_o(lo), .dbz_o(dbz)
    );

    ex_muldiv #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(start16), .op_i(op16), .opa_i(opa16),
        .opb_i(opb16), .cancel_i(cancel16), .stall_o(stall16), .res_valid_o(rv16),
        .hi_o(hi16), .lo_o(lo16), .dbz_o(dbz16)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] ehi, elo;
        logic        edbz;
        int          elat;
        int          estall;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi,
                                input logic [31:0] elo, input logic edbz);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo; v.edbz = edbz;
        v.elat   = edbz ? 2 : W + 3;
        v.estall = edbz ? 1 : W + 2;
        return v;
    endfunction

    // Reference model: plain 64-bit arithmetic. SV signed division truncates
    // toward zero and the remainder follows the dividend, as MIPS requires.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] mhi,
                                  output logic [31:0] mlo, output logic mdbz);
        longint sa, sb, sp, sq, sr;
        longint unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        mdbz = 1'b0;
        mhi = '0;
        mlo = '0;
        case (mop)
            2'd0: begin sp = sa * sb; {mhi, mlo} = sp; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; {mhi, mlo} = up; end
            default: begin
                if (b == 0) begin
                    mhi = a; mlo = '1; mdbz = 1'b1;
                end else if (mop == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    mlo = 32'(sq); mhi = 32'(sr);
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
        endcase
    endfunction

    // Launch one operation, wait (bounded) for its result, report the
    // result, the cycle index of res_valid (request cycle = 1) and the
    // number of stall cycles; also checks the pulse width and result hold.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz, output int lat, output int stalls);
        bit got;
        got = 0;
        rhi = '0; rlo = '0; rdbz = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        #1;
        lat = 1;
        stalls = stall ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            lat++;
            if (res_valid) begin
                got = 1;
                rhi = hi; rlo = lo; rdbz = dbz;
                check("stall_low_with_result", stall, 0);
                break;
            end
            if (stall) stalls++;
        end
        check("result_seen", got, 1);
        @(posedge clk); #2;
        check("res_valid_single_pulse", res_valid, 0);
        check("hi_holds", hi, rhi);
        check("lo_holds", lo, rlo);
    endtask

    logic [31:0] rhi, rlo, mhi, mlo;
    logic        rdbz, mdbz;
    int          lat, stalls, cnt;

    initial begin
        rst = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; cancel = 1'b0;
        start16 = 1'b0; op16 = '0; opa16 = '0; opb16 = '0; cancel16 = 1'b0;

        // Reset state
        #12;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_dbz", dbz, 0);
        check("reset_stall", stall, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        tbl.push_back(mk("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                         32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
        tbl.push_back(mk("mult_m3x5", 2'd0, 32'hFFFF_FFFD, 32'd5,
                         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0));
        tbl.push_back(mk("mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000,
                         32'h4000_0000, 32'h0, 1'b0));
        tbl.push_back(mk("div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2,
                         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
        tbl.push_back(mk("divu_7d2", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0));
        tbl.push_back(mk("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'h0, 32'h8000_0000, 1'b0));
        tbl.push_back(mk("divu_by_zero", 2'd3, 32'h1234, 32'h0,
                         32'h1234, 32'hFFFF_FFFF, 1'b1));
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, rhi, rlo, rdbz, lat, stalls);
            check({tbl[i].name, "_hi"}, rhi, tbl[i].ehi);
            check({tbl[i].name, "_lo"}, rlo, tbl[i].elo);
            check({tbl[i].name, "_dbz"}, rdbz, tbl[i].edbz);
            check({tbl[i].name, "_latency"}, lat, tbl[i].elat);
            check({tbl[i].name, "_stall_cycles"}, stalls, tbl[i].estall);
        end

        // Cancel in cycle 10 of a MULTU; previous result (div-by-zero) must hold.
        @(negedge clk);
        start = 1'b1; op = 2'd1; opa = 32'hFFFF_FFFF; opb = 32'd3;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        #1;
        check("cancel_stall_low", stall, 0);
        check("cancel_no_result", res_valid, 0);
        cnt = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #2;
            if (res_valid || stall) cnt++;
        end
        check("cancel_quiet_cycles", cnt, 0);
        check("cancel_hi_kept", hi, 32'h1234);
        check("cancel_lo_kept", lo, 32'hFFFF_FFFF);
        check("cancel_dbz_kept", dbz, 1);

        run_op(2'd3, 32'd100, 32'd7, rhi, rlo, rdbz, lat, stalls);
        check("after_cancel_divu_lo", rlo, 14);
        check("after_cancel_divu_hi", rhi, 2);
        check("after_cancel_divu_dbz", rdbz, 0);

        // cancel wins over a simultaneous start (a div-by-zero would answer at once)
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'd3; opa = 32'd5; opb = 32'd0;
        #1;
        check("cancel_start_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        #1;
        check("cancel_start_no_result", res_valid, 0);
        check("cancel_start_hi_kept", hi, 2);

        // Back-to-back: second MULT launched in the result cycle of the first.
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 32'hFFFF_FFFD; opb = 32'd5;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (res_valid) begin cnt = 1; break; end
        end
        check("b2b_first_seen", cnt, 1);
        model(2'd0, 32'hFFFF_FFFD, 32'd5, mhi, mlo, mdbz);
        check("b2b_first_hi", hi, mhi);
        check("b2b_first_lo", lo, mlo);
        start = 1'b1; op = 2'd0; opa = 32'h0001_2345; opb = 32'hFFFF_FFF9;
        lat = 1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            lat++;
            if (i == 0) check("b2b_first_single_pulse", res_valid, 0);
            if (res_valid) begin cnt = 1; break; end
        end
        check("b2b_second_seen", cnt, 1);
        model(2'd0, 32'h0001_2345, 32'hFFFF_FFF9, mhi, mlo, mdbz);
        check("b2b_second_hi", hi, mhi);
        check("b2b_second_lo", lo, mlo);
        check("b2b_second_latency", lat, W + 3);
        @(posedge clk); #2;
        check("b2b_second_single_pulse", res_valid, 0);

        // Reset mid-RUN: outputs clear immediately, no late result.
        @(negedge clk);
        start = 1'b1; op = 2'd1; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        check("midrun_reset_hi", hi, 0);
        check("midrun_reset_lo", lo, 0);
        check("midrun_reset_res_valid", res_valid, 0);
        check("midrun_reset_dbz", dbz, 0);
        check("midrun_reset_stall", stall, 0);
        @(negedge clk); rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (res_valid || stall) cnt++;
        end
        check("midrun_reset_discarded", cnt, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, rhi, rlo, rdbz, lat, stalls);
            model(ro, ra, rb, mhi, mlo, mdbz);
            check($sformatf("rand%0d_op%0d_%h_%h_hi", i, ro, ra, rb), rhi, mhi);
            check($sformatf("rand%0d_op%0d_%h_%h_lo", i, ro, ra, rb), rlo, mlo);
            check($sformatf("rand%0d_dbz", i), rdbz, mdbz);
            check($sformatf("rand%0d_latency", i), lat, mdbz ? 2 : W + 3);
        end

        // DATA_W=16: latency scales to 18 stall cycles, result in cycle 19.
        @(negedge clk);
        start16 = 1'b1; op16 = 2'd1; opa16 = 16'hFFFF; opb16 = 16'hFFFF;
        #1;
        lat = 1;
        stalls = stall16 ? 1 : 0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start16 = 1'b0;
            #1;
            lat++;
            if (rv16) begin cnt = 1; break; end
            if (stall16) stalls++;
        end
        check("w16_seen", cnt, 1);
        check("w16_hi", hi16, 16'hFFFE);
        check("w16_lo", lo16, 16'h0001);
        check("w16_latency", lat, 19);
        check("w16_stall_cycles", stalls, 18);
        @(posedge clk); #2;
        check("w16_single_pulse", rv16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
